// File: rtl/ui_pix_fmt_conv.sv
// Streaming RGB565<->RGB888 converter: two-stage valid/ready pipeline with per-frame mode latching.
// Define UI_PIX_DITHER_EN to build the x/y position counters and 2x2 ordered dither for mode 3.
module ui_pix_fmt_conv #(
  parameter bit COMPLEMENT_ENABLE = 1'b1,
  parameter int XY_W              = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cfg_mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  input  logic        in_sof,
  input  logic        in_eol,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data,
  output logic        out_sof,
  output logic        out_eol
);

  logic        en, accept;
  logic [1:0]  active_mode_q, active_mode_d, beat_mode;
  logic [3:0]  rb_add;
  logic [2:0]  g_add;
  logic [23:0] expanded;

  logic        s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d, s1_eol_q, s1_eol_d;
  logic [1:0]  s1_mode_q, s1_mode_d;
  logic [23:0] s1_data_q, s1_data_d;
  logic [3:0]  s1_rb_add_q, s1_rb_add_d;
  logic [2:0]  s1_g_add_q, s1_g_add_d;

  logic        out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
  logic [23:0] out_data_q, out_data_d;

  logic [8:0]  r_sum, g_sum, b_sum;
  logic [4:0]  r_sat, b_sat;
  logic [5:0]  g_sat;

  assign en        = out_ready | ~out_valid_q;
  assign in_ready  = en;
  assign accept    = in_valid & en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;

`ifdef UI_PIX_DITHER_EN
  logic [XY_W-1:0] x_q, x_d, y_q, y_d, beat_x, beat_y;
  logic [1:0]      bayer;

  // The sof beat itself sits at (0,0) regardless of where the counters were left.
  always_comb begin
    beat_x = in_sof ? '0 : x_q;
    beat_y = in_sof ? '0 : y_q;
    x_d    = x_q;
    y_d    = y_q;
    if (accept) begin
      if (in_eol) begin
        x_d = '0;
        y_d = beat_y + XY_W'(1);
      end else begin
        x_d = beat_x + XY_W'(1);
        y_d = beat_y;
      end
    end
    case ({beat_y[0], beat_x[0]})
      2'b00:   bayer = 2'd0;
      2'b01:   bayer = 2'd2;
      2'b10:   bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
    if (beat_mode == 2'd3) begin
      rb_add = {1'b0, bayer, 1'b0};
      g_add  = {1'b0, bayer};
    end else begin
      rb_add = 4'd4;
      g_add  = 3'd2;
    end
  end
`else
  always_comb begin
    rb_add = 4'd4;
    g_add  = 3'd2;
  end
`endif

  always_comb begin
    beat_mode     = in_sof ? cfg_mode : active_mode_q;
    active_mode_d = active_mode_q;
    if (accept && in_sof) active_mode_d = cfg_mode;

    expanded = COMPLEMENT_ENABLE
             ? {in_data[15:11], in_data[15:13], in_data[10:5], in_data[10:9],
                in_data[4:0], in_data[4:2]}
             : {in_data[15:11], 3'b000, in_data[10:5], 2'b00, in_data[4:0], 3'b000};

    s1_valid_d  = s1_valid_q;
    s1_sof_d    = s1_sof_q;
    s1_eol_d    = s1_eol_q;
    s1_mode_d   = s1_mode_q;
    s1_data_d   = s1_data_q;
    s1_rb_add_d = s1_rb_add_q;
    s1_g_add_d  = s1_g_add_q;
    if (en) begin
      s1_valid_d  = in_valid;
      s1_sof_d    = in_valid & in_sof;
      s1_eol_d    = in_valid & in_eol;
      s1_mode_d   = beat_mode;
      s1_data_d   = (beat_mode == 2'd1) ? expanded : in_data;
      s1_rb_add_d = rb_add;
      s1_g_add_d  = g_add;
    end
  end

  // Sums carry one extra bit so an overflow past the field maximum saturates instead of wrapping.
  always_comb begin
    r_sum = {1'b0, s1_data_q[23:16]} + {5'b0, s1_rb_add_q};
    g_sum = {1'b0, s1_data_q[15:8]}  + {6'b0, s1_g_add_q};
    b_sum = {1'b0, s1_data_q[7:0]}   + {5'b0, s1_rb_add_q};
    r_sat = r_sum[8] ? 5'h1f : r_sum[7:3];
    g_sat = g_sum[8] ? 6'h3f : g_sum[7:2];
    b_sat = b_sum[8] ? 5'h1f : b_sum[7:3];

    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_data_d  = out_data_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      out_sof_d   = s1_sof_q;
      out_eol_d   = s1_eol_q;
      out_data_d  = s1_mode_q[1] ? {8'h00, r_sat, g_sat, b_sat} : s1_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_mode_q <= 2'd0;
      s1_valid_q    <= 1'b0;
      s1_sof_q      <= 1'b0;
      s1_eol_q      <= 1'b0;
      s1_mode_q     <= 2'd0;
      s1_data_q     <= '0;
      s1_rb_add_q   <= '0;
      s1_g_add_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sof_q     <= 1'b0;
      out_eol_q     <= 1'b0;
      out_data_q    <= '0;
`ifdef UI_PIX_DITHER_EN
      x_q           <= '0;
      y_q           <= '0;
`endif
    end else begin
      active_mode_q <= active_mode_d;
      s1_valid_q    <= s1_valid_d;
      s1_sof_q      <= s1_sof_d;
      s1_eol_q      <= s1_eol_d;
      s1_mode_q     <= s1_mode_d;
      s1_data_q     <= s1_data_d;
      s1_rb_add_q   <= s1_rb_add_d;
      s1_g_add_q    <= s1_g_add_d;
      out_valid_q   <= out_valid_d;
      out_sof_q     <= out_sof_d;
      out_eol_q     <= out_eol_d;
      out_data_q    <= out_data_d;
`ifdef UI_PIX_DITHER_EN
      x_q           <= x_d;
      y_q           <= y_d;
`endif
    end
  end

endmodule

// File: tb/tb_ui_pix_fmt_conv.sv
// Scoreboard bench for ui_pix_fmt_conv: driver pushes expected beats, a negedge monitor pops and compares.
module tb_ui_pix_fmt_conv;

  localparam bit CE = 1'b1;
`ifdef UI_PIX_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_mode = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        in_eol = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        out_sof;
  logic        out_eol;

  typedef struct {
    logic [23:0] data;
    logic        sof;
    logic        eol;
  } beat_t;

  beat_t       expq[$];
  int          total = 0;
  int          bad = 0;
  int          m_mode = 0;
  int          m_x = 0;
  int          m_y = 0;
  int          ready_mode = 0;
  logic        lit_valid = 1'b0;
  logic [23:0] lit_data = '0;
  logic        held = 1'b0;
  logic [25:0] held_val = '0;

  ui_pix_fmt_conv #(.COMPLEMENT_ENABLE(CE), .XY_W(12)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eol(in_eol),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_conv(input int mode, input logic [23:0] d,
                                           input int x, input int y);
    int r, g, b, r5, g6, b5, bias, res;
    int bayer[4] = '{0, 2, 3, 1};
    r = int'(d[23:16]);
    g = int'(d[15:8]);
    b = int'(d[7:0]);
    case (mode)
      0: res = int'(d);
      1: begin
        r5 = int'(d[15:11]);
        g6 = int'(d[10:5]);
        b5 = int'(d[4:0]);
        if (CE) res = ((r5 * 8 + r5 / 4) << 16) | ((g6 * 4 + g6 / 16) << 8) | (b5 * 8 + b5 / 4);
        else    res = ((r5 * 8) << 16) | ((g6 * 4) << 8) | (b5 * 8);
      end
      default: begin
        if (mode == 3 && DITHER) begin
          bias = bayer[(y % 2) * 2 + (x % 2)];
          r5 = (r + 2 * bias) / 8;
          g6 = (g + bias) / 4;
          b5 = (b + 2 * bias) / 8;
        end else begin
          r5 = (r + 4) / 8;
          g6 = (g + 2) / 4;
          b5 = (b + 4) / 8;
        end
        if (r5 > 31) r5 = 31;
        if (g6 > 63) g6 = 63;
        if (b5 > 31) b5 = 31;
        res = (r5 << 11) | (g6 << 5) | b5;
      end
    endcase
    return res[23:0];
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks stall stability and output beats, then records any beat accepted this cycle.
  initial begin
    beat_t e;
    int    mode;
    forever begin
      @(negedge clk);
      if (rst) begin
        expq.delete();
        m_mode = 0;
        m_x = 0;
        m_y = 0;
        held = 1'b0;
      end else begin
        if (held) begin
          check_output("stall_hold", {5'b0, out_valid, out_data, out_sof, out_eol},
                       {5'b0, 1'b1, held_val});
        end
        if (out_valid && !out_ready) begin
          check_output("in_ready_stall", {31'b0, in_ready}, 32'd0);
          held = 1'b1;
          held_val = {out_data, out_sof, out_eol};
        end else begin
          held = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            check_output("unexpected_beat", {6'b0, out_data, out_sof, out_eol}, 32'hffffffff);
          end else begin
            e = expq.pop_front();
            check_output("beat", {6'b0, out_data, out_sof, out_eol}, {6'b0, e.data, e.sof, e.eol});
          end
        end
        if (in_valid && in_ready) begin
          if (in_sof) begin
            m_mode = int'(cfg_mode);
            m_x = 0;
            m_y = 0;
          end
          mode = m_mode;
          e.data = lit_valid ? lit_data : ref_conv(mode, in_data, m_x, m_y);
          e.sof = in_sof;
          e.eol = in_eol;
          expq.push_back(e);
          if (in_eol) begin
            m_x = 0;
            m_y = (m_y + 1) % 4096;
          end else begin
            m_x = (m_x + 1) % 4096;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  task automatic apply_stimulus(input logic [23:0] d, input logic sof, input logic eol,
                                input logic [1:0] mode, input logic lv, input logic [23:0] ld);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_data = d;
    in_sof = sof;
    in_eol = eol;
    cfg_mode = mode;
    lit_valid = lv;
    lit_data = ld;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check_output("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    lit_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expq.size() != 0) check_output("drain_timeout", expq.size(), 32'd0);
  endtask

  initial begin
    int gap;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_out", {5'b0, out_valid, out_data, out_sof, out_eol}, 32'd0);
    check_output("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // 565 -> 888 expansion; cfg change inside the frame must be ignored.
    apply_stimulus(24'h00F800, 1'b1, 1'b0, 2'd1, 1'b1, 24'hFF0000);
    apply_stimulus(24'h0007E0, 1'b0, 1'b0, 2'd2, 1'b1, 24'h00FF00);
    apply_stimulus(24'h008410, 1'b0, 1'b1, 2'd2, 1'b1, 24'h848284);
    apply_stimulus(24'h00FFFF, 1'b0, 1'b1, 2'd0, 1'b1, 24'hFFFFFF);
    // 888 -> 565 rounding and saturation.
    apply_stimulus(24'hFFFFFF, 1'b1, 1'b0, 2'd2, 1'b1, 24'h00FFFF);
    apply_stimulus(24'h040200, 1'b0, 1'b0, 2'd0, 1'b1, 24'h000820);
    apply_stimulus(24'h030100, 1'b0, 1'b1, 2'd1, 1'b1, 24'h000000);
    // 2x2 dither frames.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 4; p++) begin
        apply_stimulus((f == 0) ? 24'h040404 : 24'h020202, p == 0, (p % 2) == 1, 2'd3, 1'b0, '0);
      end
    end
    drain();

    // Burst under alternating backpressure.
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(24'($urandom), i == 0, i == 7, 2'd1, 1'b0, '0);
    end
    drain();
    ready_mode = 0;

    // Reset with beats in flight, then an unmarked beat must pass through.
    apply_stimulus(24'h00F800, 1'b1, 1'b0, 2'd1, 1'b0, '0);
    apply_stimulus(24'h0007E0, 1'b0, 1'b0, 2'd1, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("midreset_out", {5'b0, out_valid, out_data, out_sof, out_eol}, 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(24'h123456, 1'b0, 1'b0, 2'd1, 1'b1, 24'h123456);
    drain();

    // Randomized traffic with random backpressure and ignored markers on idle cycles.
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(24'($urandom), ($urandom % 16) == 0, ($urandom % 8) == 0,
                     2'($urandom), 1'b0, '0);
      gap = $urandom % 3;
      for (int g = 0; g < gap; g++) begin
        in_sof = 1'($urandom);
        in_eol = 1'($urandom);
        @(posedge clk);
        #1;
      end
    end
    drain();
    ready_mode = 0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
